// File: rtl/wb_master_arbiter_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_master_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4
);
  logic [NUM_MASTERS-1:0]            m_wb_cyc_i;
  logic [NUM_MASTERS-1:0]            m_wb_stb_i;
  logic [NUM_MASTERS-1:0]            m_wb_we_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_wb_sel_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_wb_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_o;
  logic [NUM_MASTERS-1:0]            m_wb_ack_o;
  logic [NUM_MASTERS-1:0]            m_wb_err_o;
  logic                              s_wb_cyc_o;
  logic                              s_wb_stb_o;
  logic                              s_wb_we_o;
  logic [SEL_WIDTH-1:0]              s_wb_sel_o;
  logic [ADDR_WIDTH-1:0]             s_wb_adr_o;
  logic [DATA_WIDTH-1:0]             s_wb_dat_o;
  logic [DATA_WIDTH-1:0]             s_wb_dat_i;
  logic                              s_wb_ack_i;
  logic                              s_wb_err_i;
  logic [NUM_MASTERS-1:0]            grant_o;
  logic                              timeout_o;

  modport slave (
    input  m_wb_cyc_i, m_wb_stb_i, m_wb_we_i, m_wb_sel_i, m_wb_adr_i, m_wb_dat_i,
    output m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
    output s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o, s_wb_adr_o, s_wb_dat_o,
    input  s_wb_dat_i, s_wb_ack_i, s_wb_err_i,
    output grant_o, timeout_o
  );

  modport master (
    output m_wb_cyc_i, m_wb_stb_i, m_wb_we_i, m_wb_sel_i, m_wb_adr_i, m_wb_dat_i,
    input  m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
    input  s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o, s_wb_adr_o, s_wb_dat_o,
    output s_wb_dat_i, s_wb_ack_i, s_wb_err_i,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between NUM_MASTERS masters, with stall timeout.
//   state | meaning
//   IDLE  | no owner; slave bus driven to 0; arbitrating among cyc requests
//   BUSY  | grantee owns the slave bus until it drops cyc
module wb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_master_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYCLES);
  localparam logic [NUM_MASTERS-1:0] GRANT_ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d, last_q, last_d;
  logic [15:0]            stall_q, stall_d;
  logic                   timeout_q, timeout_d;
  logic [IW-1:0]          pick_idx, cand;
  logic                   pick_found;
  logic                   g_cyc, g_stb, stall;

  logic                              s_cyc, s_stb, s_we;
  logic [SEL_WIDTH-1:0]              s_sel;
  logic [ADDR_WIDTH-1:0]             s_adr;
  logic [DATA_WIDTH-1:0]             s_dat;
  logic [NUM_MASTERS-1:0]            m_ack, m_err;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat;

  // Search starts just after the previous owner so every requester is served in turn.
  always_comb begin
    pick_idx   = last_q;
    pick_found = 1'b0;
    cand       = last_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_MASTERS);
      if (!pick_found && bus.m_wb_cyc_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign g_cyc = bus.m_wb_cyc_i[gidx_q];
  assign g_stb = bus.m_wb_stb_i[gidx_q];
  assign stall = (state_q == BUSY) && g_cyc && g_stb && !bus.s_wb_ack_i && !bus.s_wb_err_i
                 && !timeout_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= IW'(NUM_MASTERS - 1);
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    stall_d   = '0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          grant_d = GRANT_ONE << pick_idx;
          gidx_d  = pick_idx;
          last_d  = pick_idx;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
        if (stall) begin
          stall_d   = (stall_q < TO_MAX) ? stall_q + 16'd1 : stall_q;
          timeout_d = (stall_q == TO_LAST);
        end
      end
    endcase
  end

  // Outputs are gated by reset too, so nothing reaches either side during a reset cycle.
  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_sel = '0;
    s_adr = '0;
    s_dat = '0;
    m_ack = '0;
    m_err = '0;
    m_dat = '0;
    if (state_q == BUSY && !wb_rst_i) begin
      s_cyc = g_cyc;
      s_stb = g_stb & ~timeout_q;
      s_we  = bus.m_wb_we_i[gidx_q];
      s_sel = bus.m_wb_sel_i[int'(gidx_q)*SEL_WIDTH +: SEL_WIDTH];
      s_adr = bus.m_wb_adr_i[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat = bus.m_wb_dat_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
      m_ack[gidx_q] = bus.s_wb_ack_i;
      m_err[gidx_q] = bus.s_wb_err_i | timeout_q;
      m_dat[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH] = bus.s_wb_dat_i;
    end
  end

  assign bus.s_wb_cyc_o = s_cyc;
  assign bus.s_wb_stb_o = s_stb;
  assign bus.s_wb_we_o  = s_we;
  assign bus.s_wb_sel_o = s_sel;
  assign bus.s_wb_adr_o = s_adr;
  assign bus.s_wb_dat_o = s_dat;
  assign bus.m_wb_ack_o = m_ack;
  assign bus.m_wb_err_o = m_err;
  assign bus.m_wb_dat_o = m_dat;
  assign bus.grant_o    = grant_q;
  assign bus.timeout_o  = timeout_q;
endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 2, legal 2..4: number of Wishbone masters sharing one slave port.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32: data width.
REQ-004 The block SHALL have parameter SEL_WIDTH, default 4: byte-select width.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 255, legal 2..65535: stall cycles before a bus error is forced.
REQ-006 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-007 The block SHALL have these ports:
- wb_clk_i, input, 1: clock.
- wb_rst_i, input, 1: synchronous active-high reset.
- m_wb_cyc_i, input, NUM_MASTERS: per-master cycle.
- m_wb_stb_i, input, NUM_MASTERS: per-master strobe.
- m_wb_we_i, input, NUM_MASTERS: per-master write enable.
- m_wb_sel_i, input, NUM_MASTERS*SEL_WIDTH: packed byte selects, master k at [k*SEL_WIDTH +: SEL_WIDTH].
- m_wb_adr_i, input, NUM_MASTERS*ADDR_WIDTH: packed addresses.
- m_wb_dat_i, input, NUM_MASTERS*DATA_WIDTH: packed write data.
- m_wb_dat_o, output, NUM_MASTERS*DATA_WIDTH: packed read data.
- m_wb_ack_o, output, NUM_MASTERS: per-master ack.
- m_wb_err_o, output, NUM_MASTERS: per-master error.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, output, 1 each: slave control.
- s_wb_sel_o, output, SEL_WIDTH: slave byte select.
- s_wb_adr_o, output, ADDR_WIDTH: slave address.
- s_wb_dat_o, output, DATA_WIDTH: slave write data.
- s_wb_dat_i, input, DATA_WIDTH: slave read data.
- s_wb_ack_i, input, 1: slave ack.
- s_wb_err_i, input, 1: slave error.
- grant_o, output, NUM_MASTERS: registered one-hot grant.
- timeout_o, output, 1: one-cycle pulse on forced timeout.

Function
REQ-008 The FSM SHALL have two states, IDLE and BUSY, with the grant held in a register.
REQ-009 In IDLE, when any m_wb_cyc_i bit is 1, the block SHALL pick the first requester searching round-robin from last_grant+1 (mod NUM_MASTERS), set grant_o and last_grant, and enter BUSY on the next edge.
REQ-010 In IDLE, all s_wb_* outputs SHALL be 0.
REQ-011 In BUSY, the s_wb_cyc/stb/we/sel/adr/dat outputs SHALL combinationally equal the grantee's inputs.
REQ-012 In BUSY, the grantee's m_wb_ack_o, m_wb_err_o and m_wb_dat_o SHALL combinationally equal s_wb_ack_i, s_wb_err_i and s_wb_dat_i.
REQ-013 Non-granted masters SHALL see ack=0, err=0 and dat=0 at all times.
REQ-014 Grant SHALL be held while the grantee's cyc=1, so multi-beat and back-to-back cycles of the grantee are never interrupted.
REQ-015 When the grantee's cyc=0 in BUSY, the block SHALL return to IDLE on the next edge and clear grant_o, so there is a minimum one-cycle gap between owners.
REQ-016 A stall counter (16-bit, saturating at TIMEOUT_CYCLES) SHALL increment each BUSY cycle in which stb=1 and ack=0 and err=0, and clear on ack, err, stb=0, or in IDLE.
REQ-017 When the counter equals TIMEOUT_CYCLES-1 with stb=1 and no ack/err, the next cycle SHALL be a timeout cycle.
REQ-018 In a timeout cycle, s_wb_stb_o SHALL be forced to 0, the grantee SHALL get m_wb_err_o=1 for one cycle, timeout_o SHALL be 1 for one cycle, and the counter SHALL clear.
REQ-019 If s_wb_ack_i and s_wb_err_i are both 1, both SHALL be forwarded unchanged; the arbiter adds no priority between them.
REQ-020 Arbitration latency SHALL be exactly one cycle from cyc rising in IDLE to s_wb_cyc_o=1.

Reset
REQ-021 With wb_rst_i=1 at an edge, state SHALL become IDLE, grant_o=0, last_grant=NUM_MASTERS-1 (so master 0 wins first), stall counter=0 and timeout_o=0.
REQ-022 During and after reset, all s_wb_* outputs, m_wb_ack_o, m_wb_err_o and m_wb_dat_o SHALL be 0.
REQ-023 Reset asserted mid-transaction SHALL drop s_wb_cyc_o on the following cycle, with no ack or err delivered to the previous grantee.

Verification
REQ-024 After reset, masters 0 and 1 raise cyc/stb together -> grant_o=2'b01 one cycle later; s_wb_adr_o equals m0 address; m0 gets the ack; m1 gets ack=0.
REQ-025 m0 drops cyc while m1 is still requesting -> one IDLE cycle, then grant_o=2'b10; m1's read data 0xDEADBEEF returns only on m_wb_dat_o[63:32].
REQ-026 Both masters request continuously for 6 transactions -> grants alternate 01,10,01,10,01,10.
REQ-027 TIMEOUT_CYCLES=4, slave never acks -> after 4 stall cycles m_wb_err_o[0]=1 and timeout_o=1 for exactly one cycle, with s_wb_stb_o=0 that cycle.
REQ-028 m0 holds cyc for a 3-beat burst while m1 is requesting -> grant stays 01 for all 3 acks, with no grant switch until cyc drops.
REQ-029 wb_rst_i pulsed mid-read -> s_wb_cyc_o=0 next cycle, grant_o=0, and master 0 wins the next arbitration.
